// File: rtl/axi_pkg.sv
// Shared AXI constants and the completion-notifier state type.
// The magic word and target address are also used by the boot-start detector.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [63:0] CORE_MAGIC        = 64'hffff_ffff_ffff_ffff;
   localparam logic [63:0] DONE_ADDR_DEFAULT = 64'h0000_0000_0000_0040;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_RESP,
      ST_DONE,
      ST_ERR
   } notify_state_e;

endpackage

// File: rtl/axi_valid_hold.sv
// Single-channel valid/ready holder: raises valid on start and keeps it up
// until the handshake, remembering that the beat was accepted.
module axi_valid_hold (
   input  logic aclk,
   input  logic aresetn,
   input  logic start,
   input  logic ready,
   output logic valid,
   output logic fire,
   output logic done
);

   logic valid_reg;
   logic done_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else if (start) begin
         valid_reg <= 1'b1;
         done_reg  <= 1'b0;
      end else if (valid_reg && ready) begin
         valid_reg <= 1'b0;
         done_reg  <= 1'b1;
      end
   end

   assign valid = valid_reg;
   assign fire  = valid_reg & ready;
   assign done  = done_reg;

endmodule

// File: rtl/axi4_done_notify.sv
// Issues one single-beat AXI4 write of {exit code, magic} to a fixed address
// when the core signals completion, retrying on error responses.
module axi4_done_notify
   import axi_pkg::*;
#(
   parameter int          DATA_WIDTH = 512,
   parameter int          ADDR_WIDTH = 64,
   parameter int          ID_WIDTH   = 4,
   parameter int          AXI_ID     = 0,
   parameter logic [63:0] DONE_ADDR  = DONE_ADDR_DEFAULT,
   parameter logic [63:0] MAGIC      = CORE_MAGIC,
   parameter int          MAX_RETRY  = 3
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      done_i,
   input  logic [63:0]               exit_code_i,
   output logic [ID_WIDTH-1:0]       m_axi_awid,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [ID_WIDTH-1:0]       m_axi_bid,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic                      busy_o,
   output logic                      notified_o,
   output logic                      error_o
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   notify_state_e        state_reg, state_next;
   logic                 done_reg;
   logic [63:0]          exit_code_reg;
   logic [RETRY_W-1:0]   retry_reg;
   logic                 error_reg;
   logic                 req;
   logic                 start_send;
   logic                 aw_fire, aw_done;
   logic                 w_fire, w_done;
   logic                 unused_inputs;

   assign req = done_i & ~done_reg;

   // Only the error bit of bresp and none of bid matter to this master.
   assign unused_inputs = ^{m_axi_bid, m_axi_bresp[0]};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start_send = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               state_next = ST_SEND;
               start_send = 1'b1;
            end
         end
         ST_SEND: begin
            // Each channel counts as complete if it handshook earlier or does so now.
            if ((aw_done | aw_fire) && (w_done | w_fire)) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (m_axi_bvalid) begin
               if (!m_axi_bresp[1]) begin
                  state_next = ST_DONE;
               end else if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                  state_next = ST_SEND;
                  start_send = 1'b1;
               end else begin
                  state_next = ST_ERR;
               end
            end
         end
         ST_DONE, ST_ERR: begin
            if (!done_i) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o       = (state_reg == ST_SEND) || (state_reg == ST_RESP);
      m_axi_bready = (state_reg == ST_RESP);
      notified_o   = (state_reg == ST_DONE);
      error_o      = error_reg;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         done_reg      <= 1'b0;
         exit_code_reg <= '0;
         retry_reg     <= '0;
         error_reg     <= 1'b0;
      end else begin
         done_reg <= done_i;
         if (state_reg == ST_IDLE && req) begin
            exit_code_reg <= exit_code_i;
            retry_reg     <= '0;
         end else if (state_reg == ST_RESP && start_send) begin
            retry_reg <= retry_reg + RETRY_W'(1);
         end else if (state_reg == ST_DONE && !done_i) begin
            retry_reg <= '0;
         end
         if (state_next == ST_ERR) begin
            error_reg <= 1'b1;
         end
      end
   end

   axi_valid_hold u_aw_hold (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (start_send),
      .ready   (m_axi_awready),
      .valid   (m_axi_awvalid),
      .fire    (aw_fire),
      .done    (aw_done)
   );

   axi_valid_hold u_w_hold (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (start_send),
      .ready   (m_axi_wready),
      .valid   (m_axi_wvalid),
      .fire    (w_fire),
      .done    (w_done)
   );

   assign m_axi_awid    = ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr  = ADDR_WIDTH'(DONE_ADDR);
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_wlast   = 1'b1;

   // Payload lives entirely in the lowest 128-bit lane.
   for (genvar gi = 0; gi < DATA_WIDTH / 128; gi++) begin : g_lane
      assign m_axi_wdata[gi*128 +: 128] = (gi == 0) ? {exit_code_reg, MAGIC} : 128'd0;
   end

   for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_strb
      assign m_axi_wstrb[gi] = (gi < 16);
   end

endmodule

// File: tb/tb_axi4_done_notify.sv
// Randomized bench for axi4_done_notify: a reactive AXI slave, a per-cycle
// behavioural model of the channel rules, and directed latency/boundary cases.
module tb_axi4_done_notify;
   import axi_pkg::*;

   localparam int DW        = 512;
   localparam int AW        = 64;
   localparam int IW        = 4;
   localparam int SW        = DW / 8;
   localparam int MAX_RETRY = 3;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          done_i = 1'b0;
   logic [63:0]   exit_code_i = '0;
   logic [IW-1:0] m_axi_awid;
   logic [AW-1:0] m_axi_awaddr;
   logic [7:0]    m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic          m_axi_awvalid;
   logic          m_axi_awready = 1'b0;
   logic [DW-1:0] m_axi_wdata;
   logic [SW-1:0] m_axi_wstrb;
   logic          m_axi_wlast;
   logic          m_axi_wvalid;
   logic          m_axi_wready = 1'b0;
   logic [IW-1:0] m_axi_bid = '0;
   logic [1:0]    m_axi_bresp = '0;
   logic          m_axi_bvalid = 1'b0;
   logic          m_axi_bready;
   logic          busy_o;
   logic          notified_o;
   logic          error_o;

   axi4_done_notify dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .done_i        (done_i),
      .exit_code_i   (exit_code_i),
      .m_axi_awid    (m_axi_awid),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awlen   (m_axi_awlen),
      .m_axi_awsize  (m_axi_awsize),
      .m_axi_awburst (m_axi_awburst),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wlast   (m_axi_wlast),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bid     (m_axi_bid),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .busy_o        (busy_o),
      .notified_o    (notified_o),
      .error_o       (error_o)
   );

   initial forever #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- reactive slave ----------------
   int         aw_pct = 100;
   int         w_pct  = 100;
   int         b_pct  = 100;
   logic [1:0] resp_q[$];

   initial begin
      logic hs_aw, hs_w, hs_b, s_aw, s_w, pend_b;
      s_aw = 0; s_w = 0; pend_b = 0;
      forever begin
         @(negedge aclk);
         hs_aw = m_axi_awvalid & m_axi_awready;
         hs_w  = m_axi_wvalid & m_axi_wready;
         hs_b  = m_axi_bvalid & m_axi_bready;
         @(posedge aclk);
         #2;
         if (!aresetn) begin
            s_aw = 0; s_w = 0; pend_b = 0;
            m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
         end else begin
            if (hs_aw) s_aw = 1;
            if (hs_w)  s_w  = 1;
            if (s_aw && s_w) begin
               pend_b = 1; s_aw = 0; s_w = 0;
            end
            if (hs_b) m_axi_bvalid = 0;
            if (!m_axi_bvalid) m_axi_bresp = 2'($urandom);
            if (pend_b && !m_axi_bvalid && ($urandom_range(0, 99) < b_pct)) begin
               m_axi_bvalid = 1;
               m_axi_bid    = IW'($urandom);
               if (resp_q.size() > 0) m_axi_bresp = resp_q.pop_front();
               else                   m_axi_bresp = AXI_RESP_OKAY;
               pend_b = 0;
            end
            m_axi_awready = ($urandom_range(0, 99) < aw_pct);
            m_axi_wready  = ($urandom_range(0, 99) < w_pct);
         end
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   logic        m_awv, m_wv, m_bready, m_busy, m_notified, m_in_err, m_error;
   logic        m_aw_done, m_w_done, m_done_prev;
   logic [63:0] m_exit;
   int          m_attempts;
   int          aw_hs_total = 0;
   int          w_hs_total  = 0;
   logic [63:0] last_w_exit = '0;

   initial begin
      logic          req, hs_aw, hs_w;
      logic [DW-1:0] exp_w;
      logic [SW-1:0] exp_strb;
      m_awv = 0; m_wv = 0; m_bready = 0; m_busy = 0; m_notified = 0;
      m_in_err = 0; m_error = 0; m_aw_done = 0; m_w_done = 0; m_done_prev = 0;
      m_exit = '0; m_attempts = 0;
      exp_strb = '0;
      exp_strb[15:0] = 16'hFFFF;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            chk("reset_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy_o, notified_o, error_o}, '0);
            m_awv = 0; m_wv = 0; m_bready = 0; m_busy = 0; m_notified = 0;
            m_in_err = 0; m_error = 0; m_aw_done = 0; m_w_done = 0; m_done_prev = 0;
         end else begin
            chk("awvalid",    m_axi_awvalid, m_awv);
            chk("wvalid",     m_axi_wvalid,  m_wv);
            chk("bready",     m_axi_bready,  m_bready);
            chk("busy",       busy_o,        m_busy);
            chk("notified",   notified_o,    m_notified);
            chk("error",      error_o,       m_error);
            chk("aw_const",   {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast},
                              {4'd0, 64'h40, 8'd0, 3'd6, 2'b01, 1'b1});
            if (m_axi_wvalid) begin
               exp_w = '0;
               exp_w[63:0]   = 64'hFFFF_FFFF_FFFF_FFFF;
               exp_w[127:64] = m_exit;
               chk("wdata", m_axi_wdata, exp_w);
               chk("wstrb", m_axi_wstrb, exp_strb);
            end
            if (m_axi_awvalid && m_axi_awready) aw_hs_total++;
            if (m_axi_wvalid && m_axi_wready) begin
               w_hs_total++;
               last_w_exit = m_axi_wdata[127:64];
            end
            // Advance the model to what must hold after the coming edge.
            req = done_i && !m_done_prev;
            m_done_prev = done_i;
            hs_aw = m_awv && m_axi_awready;
            hs_w  = m_wv && m_axi_wready;
            if (!m_busy && !m_notified && !m_in_err) begin
               if (req) begin
                  m_busy = 1; m_awv = 1; m_wv = 1; m_aw_done = 0; m_w_done = 0;
                  m_attempts = 1; m_exit = exit_code_i;
               end
            end else if (m_busy) begin
               if (!m_bready) begin
                  if (hs_aw) begin m_awv = 0; m_aw_done = 1; end
                  if (hs_w)  begin m_wv = 0;  m_w_done = 1;  end
                  if (m_aw_done && m_w_done) m_bready = 1;
               end else if (m_axi_bvalid) begin
                  m_bready = 0;
                  if (!m_axi_bresp[1]) begin
                     m_busy = 0; m_notified = 1;
                  end else if (m_attempts <= MAX_RETRY) begin
                     m_attempts++;
                     m_awv = 1; m_wv = 1; m_aw_done = 0; m_w_done = 0;
                  end else begin
                     m_busy = 0; m_in_err = 1; m_error = 1;
                  end
               end
            end else if (!done_i) begin
               m_notified = 0; m_in_err = 0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_idle(input string name, input int maxc);
      int n;
      n = 0;
      while (busy_o === 1'b1) begin
         @(negedge aclk);
         n++;
         if (n > maxc) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: busy_o still 1 after %0d cycles, required 0", name, maxc);
            break;
         end
      end
   endtask

   task automatic lower_done();
      @(posedge aclk); #1;
      done_i = 0;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic raise_done(input logic [63:0] code);
      @(posedge aclk); #1;
      done_i = 1;
      exit_code_i = code;
      repeat (2) @(negedge aclk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int aw0, w0;
      logic sticky_err;
      aresetn = 0;
      repeat (3) @(posedge aclk);
      #1;
      chk("t0_reset_state", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy_o, notified_o, error_o}, '0);
      aresetn = 1;
      repeat (2) @(posedge aclk);
      #1;

      // T1: always-ready slave, OKAY, exact latencies
      aw0 = aw_hs_total; w0 = w_hs_total;
      done_i = 1; exit_code_i = 64'h2A;
      @(negedge aclk);
      chk("t1_awvalid_edge_cycle", m_axi_awvalid, 1'b0);
      @(negedge aclk);
      chk("t1_awvalid", m_axi_awvalid, 1'b1);
      chk("t1_wvalid",  m_axi_wvalid,  1'b1);
      chk("t1_awaddr",  m_axi_awaddr,  64'h40);
      chk("t1_awsize_awlen", {m_axi_awsize, m_axi_awlen}, {3'd6, 8'd0});
      chk("t1_wdata_lo", m_axi_wdata[127:0], {64'h2A, 64'hFFFF_FFFF_FFFF_FFFF});
      chk("t1_wstrb",   m_axi_wstrb, 64'hFFFF);
      chk("t1_wlast_busy_bready", {m_axi_wlast, busy_o, m_axi_bready}, 3'b110);
      @(negedge aclk);
      chk("t1_bready_rise", {m_axi_bready, notified_o}, 2'b10);
      @(negedge aclk);
      chk("t1_notified_rise", {notified_o, busy_o}, 2'b10);
      chk("t1_aw_count", aw_hs_total - aw0, 1);
      chk("t1_w_count",  w_hs_total - w0, 1);
      @(posedge aclk); #1;
      done_i = 0;
      @(negedge aclk);
      chk("t1_notified_hold", notified_o, 1'b1);
      @(negedge aclk);
      chk("t1_notified_clear", notified_o, 1'b0);
      $display("txn T1: exit=2a writes=%0d", aw_hs_total - aw0);

      // T2: awready held low, W completes first
      @(posedge aclk); #1;
      aw0 = aw_hs_total;
      aw_pct = 0;
      done_i = 1; exit_code_i = 64'h55;
      repeat (2) @(negedge aclk);
      chk("t2_valids_up", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      @(negedge aclk);
      chk("t2_w_first", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b100);
      repeat (3) begin
         @(negedge aclk);
         chk("t2_aw_hold", {m_axi_awvalid, m_axi_bready, m_axi_awaddr}, {1'b1, 1'b0, 64'h40});
      end
      @(posedge aclk); #1;
      aw_pct = 100;
      @(negedge aclk);
      wait_idle("t2", 50);
      chk("t2_notified", notified_o, 1'b1);
      chk("t2_aw_count", aw_hs_total - aw0, 1);
      $display("txn T2: exit=55 writes=%0d", aw_hs_total - aw0);
      lower_done();

      // T3: two SLVERR then OKAY
      aw0 = aw_hs_total; w0 = w_hs_total;
      resp_q.delete();
      resp_q.push_back(AXI_RESP_SLVERR);
      resp_q.push_back(AXI_RESP_SLVERR);
      raise_done(64'h1234_5678);
      wait_idle("t3", 200);
      chk("t3_aw_count", aw_hs_total - aw0, 3);
      chk("t3_w_count",  w_hs_total - w0, 3);
      chk("t3_exit", last_w_exit, 64'h1234_5678);
      chk("t3_outcome", {notified_o, error_o}, 2'b10);
      $display("txn T3: exit=12345678 writes=%0d", aw_hs_total - aw0);
      lower_done();

      // T5: done_i toggled during SEND, then a fresh notification
      aw0 = aw_hs_total;
      aw_pct = 0;
      raise_done(64'h11);
      @(posedge aclk); #1;
      done_i = 0;
      @(posedge aclk); #1;
      done_i = 1; exit_code_i = 64'h99;
      @(posedge aclk); #1;
      aw_pct = 100;
      @(negedge aclk);
      wait_idle("t5a", 50);
      chk("t5_single_write", aw_hs_total - aw0, 1);
      chk("t5_first_exit", last_w_exit, 64'h11);
      chk("t5_notified", notified_o, 1'b1);
      $display("txn T5a: exit=11 writes=%0d", aw_hs_total - aw0);
      lower_done();
      aw0 = aw_hs_total;
      raise_done(64'h7);
      wait_idle("t5b", 50);
      chk("t5_second_write", aw_hs_total - aw0, 1);
      chk("t5_second_exit", last_w_exit, 64'h7);
      $display("txn T5b: exit=7 writes=%0d", aw_hs_total - aw0);
      lower_done();

      // T4: DECERR on every attempt
      aw0 = aw_hs_total;
      resp_q.delete();
      repeat (4) resp_q.push_back(AXI_RESP_DECERR);
      raise_done(64'hDEAD);
      wait_idle("t4", 300);
      chk("t4_attempts", aw_hs_total - aw0, 4);
      chk("t4_outcome", {error_o, busy_o, notified_o}, 3'b100);
      repeat (10) @(negedge aclk);
      chk("t4_no_more_writes", aw_hs_total - aw0, 4);
      $display("txn T4: exit=dead writes=%0d", aw_hs_total - aw0);
      lower_done();
      chk("t4_error_sticky", error_o, 1'b1);

      // T6: reset while AW is stalled
      aw_pct = 0;
      raise_done(64'h3);
      chk("t6_pre_reset", m_axi_awvalid, 1'b1);
      @(posedge aclk); #3;
      aresetn = 0;
      done_i = 0;
      #1;
      chk("t6_async_clear", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy_o, error_o}, '0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1;
      aw_pct = 100;
      resp_q.delete();
      @(posedge aclk); #1;
      aw0 = aw_hs_total;
      raise_done(64'h44);
      wait_idle("t6", 50);
      chk("t6_clean_write", aw_hs_total - aw0, 1);
      chk("t6_exit", last_w_exit, 64'h44);
      chk("t6_outcome", {notified_o, error_o}, 2'b10);
      $display("txn T6: exit=44 writes=%0d", aw_hs_total - aw0);
      lower_done();

      // Random phase: random readiness, random error runs, exit code changing mid-flight
      sticky_err = 0;
      for (int it = 0; it < 50; it++) begin
         int          k, exp_att;
         logic        exp_ok;
         logic [63:0] code;
         aw_pct = $urandom_range(30, 100);
         w_pct  = $urandom_range(30, 100);
         b_pct  = $urandom_range(30, 100);
         k = $urandom_range(0, 5);
         resp_q.delete();
         for (int j = 0; j < k; j++) resp_q.push_back($urandom_range(0, 1) ? AXI_RESP_SLVERR : AXI_RESP_DECERR);
         resp_q.push_back($urandom_range(0, 1) ? AXI_RESP_OKAY : AXI_RESP_EXOKAY);
         exp_ok  = (k <= MAX_RETRY);
         exp_att = exp_ok ? k + 1 : MAX_RETRY + 1;
         if (!exp_ok) sticky_err = 1;
         code = {$urandom, $urandom};
         aw0 = aw_hs_total;
         @(posedge aclk); #1;
         done_i = 1; exit_code_i = code;
         @(posedge aclk); #1;
         exit_code_i = {$urandom, $urandom};
         @(negedge aclk);
         wait_idle("rand", 400);
         chk("rand_attempts", aw_hs_total - aw0, exp_att);
         chk("rand_exit", last_w_exit, code);
         chk("rand_outcome", {notified_o, error_o}, {exp_ok, sticky_err});
         $display("txn R%0d: exit=%h errs=%0d writes=%0d notified=%0b error=%0b",
                  it, code, k, aw_hs_total - aw0, notified_o, error_o);
         lower_done();
         repeat ($urandom_range(0, 3)) @(posedge aclk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
